// File: rtl/cp0_int_ctrl_pkg.sv
// CP0 register map, bit positions and shared types for the interrupt controller.
// Pure definitions: no logic, no latency.
// Imported by the controller, its sub-modules and the pipeline decode logic.
package cp0_int_ctrl_pkg;

    // CP0 register numbers (rd field of mfc0/mtc0)
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // SR fields
    localparam int IM_LO   = 10;
    localparam int IM_HI   = 15;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    // Cause fields
    localparam int IP_LO  = 10;
    localparam int IP_HI  = 15;
    localparam int EXC_LO = 2;
    localparam int EXC_HI = 6;

    // ExcCode for an external interrupt
    localparam logic [4:0] EXC_INT = 5'd0;

    // EXL viewed as a two-state machine
    typedef enum logic {
        USER    = 1'b0,
        HANDLER = 1'b1
    } exlState_t;

    // Assemble the architectural SR word; unimplemented bits read as 0
    function automatic logic [31:0] packSr(input logic [5:0] im, input logic exl,
                                           input logic ie);
        logic [31:0] w;
        w                = 32'h0;
        w[IM_HI:IM_LO]   = im;
        w[EXL_BIT]       = exl;
        w[IE_BIT]        = ie;
        return w;
    endfunction

    // Assemble the architectural Cause word
    function automatic logic [31:0] packCause(input logic [5:0] ip, input logic [4:0] exc);
        logic [31:0] w;
        w                = 32'h0;
        w[IP_HI:IP_LO]   = ip;
        w[EXC_HI:EXC_LO] = exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Pipeline-facing bus of the CP0 interrupt controller (mfc0/mtc0, eret, interrupt).
// No logic, no latency.
// No handshake: the pipeline stalls around mfc0-after-mtc0 hazards itself.
interface cp0_int_ctrl_if;
    logic [5:0]  hwint;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic        exl_clr;
    logic [31:0] pc;
    logic        intreq;
    logic [29:0] epc;
    logic [31:0] dout;

    // Pipeline side
    modport master (
        output hwint, a1, a2, din, we, exl_clr, pc,
        input  intreq, epc, dout
    );

    // Controller side
    modport slave (
        input  hwint, a1, a2, din, we, exl_clr, pc,
        output intreq, epc, dout
    );
endinterface

// File: rtl/cp0_int_ctrl_sync.sv
// Flop chain on the device interrupt lines; last stage is Cause.IP.
// Latency STAGES cycles from d to q; updates every cycle.
// No backpressure: level signals, sampled unconditionally.
module cp0_int_ctrl_sync #(
    parameter int STAGES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] d,
    output logic [5:0] q
);

    logic [5:0] chain [STAGES];

    // Shift the raw lines through the chain; reset clears every stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= 6'h0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId, interrupt request and mfc0 read mux.
// intreq is combinational from registers; hwint reaches IP after SYNC_STAGES cycles.
// No backpressure: mtc0/eret/interrupt take effect on the next edge unconditionally.
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter int          SYNC_STAGES = 1,
    parameter logic [31:0] PRID        = 32'h0000_4D50
) (
    input  logic         clk,
    input  logic         reset,
    cp0_int_ctrl_if.slave bus
);

    logic [5:0]  causeIp;
    logic [4:0]  excCode;
    logic [5:0]  srIm;
    logic        srIe;
    logic        srExl;
    logic [29:0] epcReg;
    logic        intReq;
    logic        srWr;
    logic        epcWr;
    exlState_t   state;
    exlState_t   stateNext;
    logic        unusedPcLow;

    // Word alignment bits of the victim PC are not architecturally stored
    assign unusedPcLow = ^bus.pc[1:0];

    assign srWr  = bus.we && (bus.a2 == REG_SR);
    assign epcWr = bus.we && (bus.a2 == REG_EPC);

    // Device lines are resynchronised before they become visible as IP
    cp0_int_ctrl_sync #(
        .STAGES (SYNC_STAGES)
    ) uSync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.hwint),
        .q     (causeIp)
    );

    // Request only depends on registered state, never directly on hwint
    assign intReq = (|(causeIp & srIm)) & srIe & ~srExl;

    // EXL state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= USER;
        end else begin
            state <= stateNext;
        end
    end

    // EXL next state: taking an interrupt wins, then eret, then software write
    always_comb begin
        stateNext = state;
        if (intReq) begin
            stateNext = HANDLER;
        end else if (bus.exl_clr) begin
            stateNext = USER;
        end else if (srWr) begin
            stateNext = bus.din[EXL_BIT] ? HANDLER : USER;
        end
    end

    // EXL bit as seen by SR and the request equation
    always_comb begin
        srExl = 1'b0;
        if (state == HANDLER) begin
            srExl = 1'b1;
        end
    end

    // IM/IE are software-owned and only change on mtc0 SR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srIm <= 6'h0;
            srIe <= 1'b0;
        end else if (srWr) begin
            srIm <= bus.din[IM_HI:IM_LO];
            srIe <= bus.din[IE_BIT];
        end
    end

    // EPC captures the victim PC on interrupt, otherwise takes mtc0 EPC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epcReg <= 30'h0;
        end else if (intReq) begin
            epcReg <= bus.pc[31:2];
        end else if (epcWr) begin
            epcReg <= bus.din[31:2];
        end
    end

    // ExcCode records the cause of the last exception; only interrupts exist here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            excCode <= 5'd0;
        end else if (intReq) begin
            excCode <= EXC_INT;
        end
    end

    // mfc0 read mux returns pre-edge values; same-cycle mtc0 is not forwarded
    always_comb begin
        bus.dout = 32'h0;
        case (bus.a1)
            REG_SR:    bus.dout = packSr(srIm, srExl, srIe);
            REG_CAUSE: bus.dout = packCause(causeIp, excCode);
            REG_EPC:   bus.dout = {epcReg, 2'b00};
            REG_PRID:  bus.dout = PRID;
            default:   bus.dout = 32'h0;
        endcase
    end

    assign bus.intreq = intReq;
    assign bus.epc    = epcReg;

endmodule
